// File: rtl/matrix_scan_controller.sv
// Row-scan sequencer for an 8x8 LED dot matrix with a double-buffered frame
// store. A divided scan tick paces each row through BLANK then DRIVE; the
// front/back swap is deferred to the frame boundary (row 7 DRIVE->BLANK).
module matrix_scan_controller #(
  parameter int unsigned TICK_DIV    = 5000,
  parameter int unsigned BLANK_TICKS = 1,
  parameter int unsigned DRIVE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] row_out,
  output logic [7:0] col_out
);

  localparam int unsigned CW     = $clog2(TICK_DIV);
  localparam int unsigned PH_MAX = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_TICKS - 1);
  localparam logic [PW-1:0] DRIVE_LAST = PW'(DRIVE_TICKS - 1);

  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] phase;
  logic [2:0]    row;
  logic          buf_sel;
  logic          swap_pending;
  logic          tick;
  logic          boundary;

  // Frame store: entries {buf, row}; buf_sel names the front buffer
  logic [7:0] mem [16];

  // Scan tick and frame-boundary decode from the current state
  always_comb begin
    tick     = (state != OFF) && (cnt == CNT_LAST);
    boundary = tick && (state == DRIVE) && (phase == DRIVE_LAST) && (row == 3'd7);
  end

  // Back-buffer writes; the swap edge still sees the pre-swap buf_sel
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 16; i++) begin
        mem[i[3:0]] <= '0;
      end
    end else if (wr_en) begin
      mem[{~buf_sel, wr_row}] <= wr_data;
    end
  end

  // Scan FSM with tick divider, phase/row counters, swap handshake and outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= OFF;
      cnt          <= '0;
      phase        <= '0;
      row          <= '0;
      buf_sel      <= 1'b0;
      swap_pending <= 1'b0;
      row_out      <= '0;
      col_out      <= '1;
      swap_ack     <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      if (!enable) begin
        state        <= OFF;
        cnt          <= '0;
        phase        <= '0;
        row          <= '0;
        swap_pending <= 1'b0;
        row_out      <= '0;
        col_out      <= '1;
      end else begin
        cnt <= ((state == OFF) || tick) ? '0 : cnt + 1'b1;
        if (swap_req && !boundary) begin
          swap_pending <= 1'b1;
        end
        unique case (state)
          OFF: begin
            state       <= BLANK;
            row         <= '0;
            phase       <= '0;
            frame_start <= 1'b1;
          end
          BLANK: begin
            if (tick) begin
              if (phase == BLANK_LAST) begin
                state   <= DRIVE;
                phase   <= '0;
                row_out <= 8'd1 << row;
                col_out <= ~mem[{buf_sel, row}];
              end else begin
                phase <= phase + 1'b1;
              end
            end
          end
          DRIVE: begin
            if (tick) begin
              if (phase == DRIVE_LAST) begin
                state   <= BLANK;
                phase   <= '0;
                row     <= row + 3'd1;
                row_out <= '0;
                col_out <= '1;
                if (row == 3'd7) begin
                  frame_start <= 1'b1;
                  if (swap_pending || swap_req) begin
                    buf_sel      <= ~buf_sel;
                    swap_ack     <= 1'b1;
                    swap_pending <= 1'b0;
                  end
                end
              end else begin
                phase <= phase + 1'b1;
              end
            end
          end
          default: state <= OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with TICK_DIV=4, BLANK_TICKS=1,
// DRIVE_TICKS=2: each row is 4 blank cycles then 8 drive cycles, 96 per frame.
module tb_matrix_scan_controller;

  localparam int ROW_CYC   = 12;
  localparam int BLANK_CYC = 4;
  localparam int FRAME_CYC = 96;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [7:0] row_out;
  logic [7:0] col_out;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [17:0] IDLE = {8'h00, 8'hFF, 1'b0, 1'b0};

  matrix_scan_controller #(
    .TICK_DIV   (4),
    .BLANK_TICKS(1),
    .DRIVE_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .row_out    (row_out),
    .col_out    (col_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {row_out, col_out, frame_start, swap_ack};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d: observed row=%h col=%h fs=%b ack=%b, expected row=%h col=%h fs=%b ack=%b",
             tag, k, obs[17:10], obs[9:2], obs[1], obs[0], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Called while observing k=0 of a frame (the frame_start cycle). Checks every
  // cycle k < stop_k against the expected front pattern, applying swap_req on
  // cycles flagged in req_at and back-buffer writes of masked rows starting at
  // wbase (row i written at k = wbase+i). Returns while observing k = stop_k.
  task automatic frame(input string tag, input logic [63:0] pat, input logic ack0,
                       input logic [95:0] req_at, input int wbase,
                       input logic [7:0] wmask, input logic [63:0] wpat,
                       input int stop_k);
    for (int k = 0; k < stop_k; k++) begin
      int r;
      int p;
      int wi;
      logic [7:0] ro;
      logic [7:0] co;
      logic fs_e;
      logic ack_e;
      r = k / ROW_CYC;
      p = k % ROW_CYC;
      if (p < BLANK_CYC) begin
        ro = 8'h00;
        co = 8'hFF;
      end else begin
        ro = 8'h01 << r;
        co = ~pat[8*r +: 8];
      end
      fs_e  = (k == 0);
      ack_e = (k == 0) ? ack0 : 1'b0;
      check(tag, k, {ro, co, fs_e, ack_e});
      swap_req = req_at[k];
      wr_en    = 1'b0;
      wi       = k - wbase;
      if (wbase >= 0 && wi >= 0 && wi < 8) begin
        if (wmask[wi]) begin
          wr_en   = 1'b1;
          wr_row  = 3'(wi);
          wr_data = wpat[8*wi +: 8];
        end
      end
      step();
      swap_req = 1'b0;
      wr_en    = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p1, p2, p2b, p3, wp5, none;
    logic [95:0] rq;

    for (int r = 0; r < 8; r++) begin
      p1[8*r +: 8] = 8'h01 << r;
      p2[8*r +: 8] = 8'hA0 | 8'(r);
      p3[8*r +: 8] = 8'h80 >> r;
    end
    p2b        = p2;
    p2b[7:0]   = 8'h5A;
    wp5        = '0;
    wp5[47:40] = 8'hAA;
    none       = '0;

    rst      = 1'b0;
    enable   = 1'b0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_data  = '0;
    swap_req = 1'b0;

    // Power-on reset
    step();
    step();
    check("reset", 0, IDLE);
    rst = 1'b1;
    step();
    check("off_idle", 0, IDLE);

    // Load back buffer with one-hot rows while off
    for (int r = 0; r < 8; r++) begin
      wr_en   = 1'b1;
      wr_row  = 3'(r);
      wr_data = 8'h01 << r;
      step();
    end
    wr_en = 1'b0;

    // Enable together with a swap request: entry edge is not a boundary
    enable   = 1'b1;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;

    frame("f0_dark", none, 1'b0, '0, -1, 8'h00, none, FRAME_CYC);
    frame("f1_scan", p1, 1'b1, '0, -1, 8'h00, none, FRAME_CYC);

    // Second scan frame; one swap_req mid-row-2 and P2 written during row 3 drive
    rq = '0;
    rq[30] = 1'b1;
    frame("f2_scan", p1, 1'b0, rq, 40, 8'hFF, p2, FRAME_CYC);

    // Three requests in one frame collapse to a single swap
    rq = '0;
    rq[10] = 1'b1;
    rq[50] = 1'b1;
    rq[80] = 1'b1;
    frame("f3_hs", p2, 1'b1, rq, 60, 8'hFF, p3, FRAME_CYC);

    // Request and row-0 write only on the boundary edge
    rq = '0;
    rq[95] = 1'b1;
    frame("f4_bnd", p3, 1'b1, rq, 95, 8'h01, {56'h0, 8'h5A}, FRAME_CYC);

    // New front shows row0=5A; back[5]=AA written during row 5 drive stays hidden
    frame("f5_iso", p2b, 1'b1, '0, 65, 8'h20, wp5, FRAME_CYC);

    // No swap at the following boundary; set pending, then drop enable mid row 4
    rq = '0;
    rq[20] = 1'b1;
    frame("f6_en", p2b, 1'b0, rq, -1, 8'h00, none, 54);
    check("en_row4", 54, {8'h10, ~p2b[39:32], 1'b0, 1'b0});
    enable = 1'b0;
    step();
    check("en_drop", 0, IDLE);
    for (int i = 1; i < 4; i++) begin
      step();
      check("en_off", i, IDLE);
    end
    enable = 1'b1;
    step();

    // Re-entry: frame_start, no ack, display unchanged, pending cleared
    frame("f7_reen", p2b, 1'b0, '0, -1, 8'h00, none, FRAME_CYC);
    frame("f8_reen", p2b, 1'b0, '0, -1, 8'h00, none, 40);

    // Reset mid-drive of row 3 with enable still high
    check("rst_row3", 40, {8'h08, ~p2b[31:24], 1'b0, 1'b0});
    rst = 1'b0;
    step();
    check("rst_mid", 0, IDLE);
    rst = 1'b1;
    step();

    // Both buffers cleared: dark before and after a swap
    rq = '0;
    rq[5] = 1'b1;
    frame("r0_dark", none, 1'b0, rq, -1, 8'h00, none, FRAME_CYC);
    frame("r1_dark", none, 1'b1, '0, -1, 8'h00, none, FRAME_CYC);
    check("r2_start", 0, {8'h00, 8'hFF, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_scan_controller.md
# matrix_scan_controller

Row-scan sequencer for the 8x8 LED dot-matrix display. It holds a double-buffered 8x8 frame store and derives its own scan tick from the 50 MHz system clock. Each row is driven in turn, with a blanking gap between rows to suppress ghosting. The front/back buffer swap happens only at a frame boundary, on a request/acknowledge handshake from the pattern generator that writes the back buffer.

## Interface
- TICK_DIV, 5000: clk cycles per scan tick (50 MHz / 5000 = 10 kHz tick); must be >= 2.
- BLANK_TICKS, 1: ticks per row spent blanked; must be >= 1.
- DRIVE_TICKS, 4: ticks per row spent driving LEDs; must be >= 1.
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-low
- enable  in  1  scan enable; low forces display dark and scan to idle
- wr_en  in  1  write one row of the back buffer this cycle
- wr_row  in  3  back-buffer row index for the write
- wr_data  in  8  row pixel data, bit i = column i, 1 = LED on
- swap_req  in  1  request front/back swap at the next frame boundary
- swap_ack  out  1  one-cycle pulse in the cycle the swap takes effect
- frame_start  out  1  one-cycle pulse on entry to BLANK of row 0
- row_out  out  8  one-hot row drive, active-high, 0 when blanked
- col_out  out  8  column drive, active-low, 8'hFF when blanked

## Operation
- State: two buffers of 8x8 bits, buf_sel (front index), row (3 bits), tick counter, phase counter, swap_pending, FSM {OFF, BLANK, DRIVE}.
- Tick: counter runs 0..TICK_DIV-1 only when FSM != OFF. tick = (count == TICK_DIV-1). count is held at 0 in OFF.
- OFF: row_out=0, col_out=8'hFF. Moves to BLANK with row=0, phase=0 when enable=1. frame_start pulses in that same update.
- BLANK: row_out=0, col_out=8'hFF. On the BLANK_TICKS-th tick, moves to DRIVE and sets row_out = 1<<row, col_out = ~front[row].
- DRIVE: outputs are held. On the DRIVE_TICKS-th tick, moves to BLANK with row = row+1 (7 wraps to 0).
- Frame boundary: the DRIVE→BLANK transition of row 7. frame_start pulses at every boundary.
- Swap at the boundary: if swap_pending | swap_req, then toggle buf_sel, pulse swap_ack, and clear swap_pending.
- Swap request: swap_req=1 outside a boundary sets swap_pending. Repeated requests before the boundary collapse to one swap.
- Writes: wr_en writes wr_data to back[wr_row] on any cycle, in any state. A write in the swap cycle goes to the pre-swap back buffer, which becomes the new front.
- Front buffer contents are never modified, so col_out is stable throughout DRIVE.
- enable=0 in any state: next edge goes to OFF, row=0, phase=0, and swap_pending is cleared. Buffers and buf_sel are kept.

## Timing
- All outputs are registered. Every state/output change occurs on the clk edge where tick=1, except the OFF→BLANK entry, which occurs on the first edge with enable=1.
- Row period = (BLANK_TICKS+DRIVE_TICKS)*TICK_DIV cycles. Frame period = 8x the row period. With defaults: 500 us per row, 4 ms per frame.
- swap_req to swap_ack latency: the next frame boundary, 0 to one frame period. If swap_req is high on the boundary edge, the ack comes on that same edge.
- swap_ack and frame_start assert together at a swapping boundary, each for exactly 1 cycle.
- Reset (rst=0 on an edge), including mid-frame:
  - FSM=OFF, counters=0, row=0, buf_sel=0, swap_pending=0, both buffers cleared to 0.
  - row_out=0, col_out=8'hFF, swap_ack=0, frame_start=0.
  - Reset has priority over all other inputs.

## Test plan
Benches use TICK_DIV=4, BLANK_TICKS=1, DRIVE_TICKS=2 (12 cycles/row, 96 cycles/frame).

1. **Reset values.** Assert rst=0 mid-DRIVE of row 3 → next edge row_out=0, col_out=FF, swap_ack=0, frame_start=0; after release with enable=1, scan restarts at row 0 and all rows show col_out=FF.
2. **Scan order.** Write back rows 0..7 = 8'h01<<r, swap, then run two frames:
   - row_out steps 01,02,…,80 then back to 01;
   - col_out = ~(1<<r) during DRIVE and FF during BLANK;
   - each DRIVE lasts 8 cycles, each BLANK lasts 4.
3. **Handshake.** Pulse swap_req for one cycle mid-row-2 → exactly one swap_ack, coincident with frame_start at the row-7 DRIVE→BLANK edge; the new pattern appears from row 0. Three swap_req pulses in one frame → one ack.
4. **Boundary swap.** swap_req high only on the boundary edge → swap_ack that same edge, and no swap at the following boundary. A write to row 0 on that edge appears on row 0 in the new frame.
5. **Back-buffer isolation.** Writes to back rows during DRIVE (e.g. back[5]=AA) → col_out unchanged until a swap.
6. **Enable drop.** Drop enable mid-DRIVE row 4 with swap_pending set → next edge col_out=FF, row_out=0. On re-enable, frame_start pulses, row 0 follows, no swap_ack occurs, and the displayed buffer is unchanged.
